pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central pipeline controller; drives the stall/flush inputs of every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the PC.
//  Merges per-stage stall requests into a cumulative stall vector.
//  Holds trap/branch redirects until the pipeline can consume them.
//  Keeps stall/redirect performance counters and a stall watchdog.
// PARAMETERS
//  CNT_W          32    width of perf counters stall_cycles, redirect_count (wrap modulo 2^CNT_W)
//  STALL_TIMEOUT  1024  consecutive stall_if cycles before stall_timeout sets; 0 disables watchdog
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      reset, asynchronous, active-high
//  stallreq_if     in   1      instruction bus wait
//  stallreq_id     in   1      load-use hazard
//  stallreq_ex     in   1      multi-cycle EX op busy (mult/div)
//  stallreq_mem    in   1      data bus wait
//  trap_req        in   1      exception/eret committed in MEM, one-cycle pulse
//  trap_pc         in   32     handler/EPC target, valid with trap_req
//  branch_req      in   1      mispredict resolved in EX, one-cycle pulse
//  branch_pc       in   32     correct target, valid with branch_req
//  stall_if        out  1      stall PC / if_id
//  stall_id        out  1      stall if_id -> id_ex
//  stall_ex        out  1      stall id_ex -> ex_mem
//  stall_mem       out  1      stall ex_mem -> mem_wb
//  trap            out  1      flush for pipeline registers (trap)
//  branch_flag     out  1      flush for if_id/id_ex (mispredict)
//  redirect_pc     out  32     PC load value while trap|branch_flag
//  stall_cycles    out  CNT_W  cycles with stall_if=1
//  redirect_count  out  CNT_W  redirects consumed
//  stall_timeout   out  1      sticky watchdog flag
// BEHAVIOUR
//  Stall vector, combinational, zero latency:
//   stall_mem = stallreq_mem; stall_ex = stall_mem|stallreq_ex;
//   stall_id = stall_ex|stallreq_id; stall_if = stall_id|stallreq_if.
//   A stage stalls when it or any later stage requests a stall.
//   id_ex then bubbles on stall_id&~stall_ex.
//  Redirect state: IDLE, TRAP_PEND, BR_PEND; regs pend_pc[31:0].
//   trap = trap_req | (state==TRAP_PEND).
//   branch_flag = ~trap & (branch_req | state==BR_PEND).
//   redirect_pc = trap_req ? trap_pc : branch_req&~trap ? branch_pc : pend_pc.
//   Cases where no request is live take pend_pc.
//  Consumption: a redirect is consumed in a cycle with (trap|branch_flag) & ~stall_if.
//   On consumption, next state is IDLE and redirect_count++.
//  If not consumed: trap_req -> TRAP_PEND, pend_pc<=trap_pc, from any state.
//   A trap overrides a pending branch.
//  If not consumed: branch_req with state IDLE/BR_PEND and no trap -> BR_PEND, pend_pc<=branch_pc.
//  Trap and branch in the same cycle: trap wins; the branch is dropped.
//  branch_req during TRAP_PEND: ignored.
//  While pending, flush outputs stay high every cycle.
//   Repeated flush of id_ex is idempotent, so this is harmless.
//  Counters: stall_cycles++ each cycle with stall_if=1.
//   Both counters wrap silently at all-ones.
//  Watchdog: run counter increments while stall_if=1 and clears when stall_if=0.
//   When the run counter reaches STALL_TIMEOUT, stall_timeout <= 1 and holds until rst.
//  Reset (async): state=IDLE, pend_pc=0, counters=0, run=0, stall_timeout=0.
//   With all requests low, every output is 0.
//   A pending redirect is lost on reset.
// STRUCTURE
//  defines.svh gains:
//   typedef enum logic[1:0] {RD_IDLE, RD_TRAP, RD_BR} redir_state_t.
//   typedef struct {bit_t if_, id, ex, mem;} stall_t.
//  Sub-module: perf_counter #(CNT_W), with clk/rst/inc/value; two instances.
//  Everything else is inline.
// TESTING
//  1. stallreq_ex=1 only -> stall_if/id/ex=1, stall_mem=0; stall_cycles +1 per cycle.
//  2. branch_req, branch_pc=32'h8000_0100, no stalls -> branch_flag=1 and redirect_pc=32'h8000_0100 that cycle; count=1; next cycle 0.
//  3. trap_req, trap_pc=32'h8000_0180, with stallreq_mem=1 for 3 cycles -> trap held 4 cycles, redirect_pc stable, count +1 once.
//  4. Pending branch (pc 0x100) then trap_req (pc 0x180) while stalled -> branch_flag drops, trap=1, redirect_pc=0x180.
//  5. Same-cycle trap_req+branch_req, no stall -> trap=1, branch_flag=0, redirect_pc=trap_pc.
//  6. STALL_TIMEOUT=4, stallreq_if held 4 cycles -> stall_timeout=1, stays 1 after release; async rst mid-pend clears all.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline controller: redirect FSM states and the
// per-stage stall vector.
package pipeline_ctrl_pkg;

    typedef logic bit_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_TRAP,
        RD_BR
    } redir_state_t;

    typedef struct packed {
        bit_t if_;
        bit_t id;
        bit_t ex;
        bit_t mem;
    } stall_t;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running event counter; wraps silently at all-ones.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    // Count one per cycle with inc high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: cumulative stall vector, trap/branch redirect
// holding, performance counters and a sticky stall watchdog.
//
// Redirect handshake: a redirect (trap or branch_flag high) is offered every
// cycle until a cycle where stall_if is low; that cycle is the one where the
// PC and pipeline registers consume it. A live trap always beats a branch.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             trap_req,
    input  logic [31:0]      trap_pc,
    input  logic             branch_req,
    input  logic [31:0]      branch_pc,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             trap,
    output logic             branch_flag,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count,
    output logic             stall_timeout
);

    localparam int RUN_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT);

    stall_t       stall;
    redir_state_t state, state_next;
    logic [31:0]  pend_pc, pend_pc_next;
    logic         consume;
    logic [RUN_W-1:0] run;

    // Stall propagates backwards: a stage stalls if it or any later stage asks.
    always_comb begin
        stall.mem = stallreq_mem;
        stall.ex  = stall.mem | stallreq_ex;
        stall.id  = stall.ex  | stallreq_id;
        stall.if_ = stall.id  | stallreq_if;
    end

    assign stall_mem = stall.mem;
    assign stall_ex  = stall.ex;
    assign stall_id  = stall.id;
    assign stall_if  = stall.if_;

    // Redirect state and held target register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RD_IDLE;
            pend_pc <= '0;
        end else begin
            state   <= state_next;
            pend_pc <= pend_pc_next;
        end
    end

    // Flush outputs, redirect target and next redirect state.
    always_comb begin
        state_next   = state;
        pend_pc_next = pend_pc;
        trap         = trap_req | (state == RD_TRAP);
        branch_flag  = ~trap & (branch_req | (state == RD_BR));
        redirect_pc  = pend_pc;
        if (trap_req) begin
            redirect_pc = trap_pc;
        end else if (branch_req && !trap) begin
            redirect_pc = branch_pc;
        end
        consume = (trap | branch_flag) & ~stall.if_;
        if (consume) begin
            state_next = RD_IDLE;
        end else if (trap_req) begin
            // A new trap replaces any pending branch.
            state_next   = RD_TRAP;
            pend_pc_next = trap_pc;
        end else if (branch_req && state != RD_TRAP) begin
            state_next   = RD_BR;
            pend_pc_next = branch_pc;
        end
    end

    // Stall watchdog: length of the current stall_if run, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run           <= '0;
            stall_timeout <= 1'b0;
        end else if (!stall.if_) begin
            run <= '0;
        end else begin
            if (run != RUN_MAX) begin
                run <= run + RUN_W'(1);
            end
            if (STALL_TIMEOUT != 0 && (run + RUN_W'(1)) == RUN_MAX) begin
                stall_timeout <= 1'b1;
            end
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall.if_),
        .value (stall_cycles)
    );

    perf_counter #(.CNT_W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (consume),
        .value (redirect_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stall-vector table plus hand-written
// redirect, counter and watchdog sequences.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        trap_req, branch_req;
    logic [31:0] trap_pc, branch_pc;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        trap, branch_flag, stall_timeout;
    logic [31:0] redirect_pc, stall_cycles, redirect_count;

    int total_checks;
    int passed_checks;

    typedef struct {
        logic [3:0] req;   // {if, id, ex, mem}
        logic [3:0] exp;   // {stall_if, stall_id, stall_ex, stall_mem}
    } vec_t;

    vec_t vecs[16];

    pipeline_ctrl #(.CNT_W(32), .STALL_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .trap_req       (trap_req),
        .trap_pc        (trap_pc),
        .branch_req     (branch_req),
        .branch_pc      (branch_pc),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .stall_ex       (stall_ex),
        .stall_mem      (stall_mem),
        .trap           (trap),
        .branch_flag    (branch_flag),
        .redirect_pc    (redirect_pc),
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count),
        .stall_timeout  (stall_timeout)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic clr_inputs();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        trap_req     = 1'b0;
        trap_pc      = 32'h0;
        branch_req   = 1'b0;
        branch_pc    = 32'h0;
    endtask

    // Advance past the next rising edge; inputs are changed here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample point.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {28'h0, stall_if, stall_id, stall_ex, stall_mem}, 32'h0);
        chk({tag, "_flush"}, {30'h0, trap, branch_flag}, 32'h0);
        chk({tag, "_rpc"}, redirect_pc, 32'h0);
        chk({tag, "_scyc"}, stall_cycles, 32'h0);
        chk({tag, "_rcnt"}, redirect_count, 32'h0);
        chk({tag, "_wdog"}, {31'h0, stall_timeout}, 32'h0);
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        clr_inputs();
        rst = 1'b1;

        vecs[0]  = '{4'b0000, 4'b0000};
        vecs[1]  = '{4'b0001, 4'b1111};
        vecs[2]  = '{4'b0010, 4'b1110};
        vecs[3]  = '{4'b0011, 4'b1111};
        vecs[4]  = '{4'b0100, 4'b1100};
        vecs[5]  = '{4'b0101, 4'b1111};
        vecs[6]  = '{4'b0110, 4'b1110};
        vecs[7]  = '{4'b0111, 4'b1111};
        vecs[8]  = '{4'b1000, 4'b1000};
        vecs[9]  = '{4'b1001, 4'b1111};
        vecs[10] = '{4'b1010, 4'b1110};
        vecs[11] = '{4'b1011, 4'b1111};
        vecs[12] = '{4'b1100, 4'b1100};
        vecs[13] = '{4'b1101, 4'b1111};
        vecs[14] = '{4'b1110, 4'b1110};
        vecs[15] = '{4'b1111, 4'b1111};

        // Reset state
        do_reset();
        sample();
        chk_all_zero("reset");
        tick();

        // Stall vector table, one row per cycle
        for (int i = 0; i < 16; i++) begin
            {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = vecs[i].req;
            sample();
            chk($sformatf("vec%0d_stall", i), {28'h0, stall_if, stall_id, stall_ex, stall_mem},
                {28'h0, vecs[i].exp});
            chk($sformatf("vec%0d_flush", i), {30'h0, trap, branch_flag}, 32'h0);
            tick();
        end
        clr_inputs();
        sample();
        chk("table_scyc", stall_cycles, 32'd15);

        // 1: EX busy only
        do_reset();
        stallreq_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t1_stall", {28'h0, stall_if, stall_id, stall_ex, stall_mem}, 32'hE);
            chk("t1_scyc", stall_cycles, 32'(i));
            tick();
        end
        stallreq_ex = 1'b0;
        sample();
        chk("t1_scyc_end", stall_cycles, 32'd3);
        chk("t1_wdog_3cyc", {31'h0, stall_timeout}, 32'h0);
        tick();

        // 2: branch, no stall, consumed immediately
        branch_req = 1'b1;
        branch_pc  = 32'h8000_0100;
        sample();
        chk("t2_bflag", {31'h0, branch_flag}, 32'h1);
        chk("t2_trap", {31'h0, trap}, 32'h0);
        chk("t2_rpc", redirect_pc, 32'h8000_0100);
        chk("t2_rcnt0", redirect_count, 32'd0);
        tick();
        clr_inputs();
        sample();
        chk("t2_bflag_after", {31'h0, branch_flag}, 32'h0);
        chk("t2_rcnt1", redirect_count, 32'd1);
        tick();

        // 3: trap held across 3 stalled cycles
        trap_req     = 1'b1;
        trap_pc      = 32'h8000_0180;
        stallreq_mem = 1'b1;
        sample();
        chk("t3_trap_c0", {31'h0, trap}, 32'h1);
        chk("t3_rpc_c0", redirect_pc, 32'h8000_0180);
        tick();
        trap_req = 1'b0;
        trap_pc  = 32'hDEAD_BEEF;
        for (int i = 1; i < 3; i++) begin
            sample();
            chk("t3_trap_held", {31'h0, trap}, 32'h1);
            chk("t3_rpc_held", redirect_pc, 32'h8000_0180);
            chk("t3_rcnt_held", redirect_count, 32'd1);
            tick();
        end
        stallreq_mem = 1'b0;
        sample();
        chk("t3_trap_c3", {31'h0, trap}, 32'h1);
        chk("t3_rpc_c3", redirect_pc, 32'h8000_0180);
        tick();
        clr_inputs();
        sample();
        chk("t3_trap_done", {31'h0, trap}, 32'h0);
        chk("t3_rcnt", redirect_count, 32'd2);
        chk("t3_scyc", stall_cycles, 32'd6);
        tick();

        // 4: pending branch overridden by a trap while stalled
        stallreq_mem = 1'b1;
        branch_req   = 1'b1;
        branch_pc    = 32'h0000_0100;
        sample();
        chk("t4_bflag_c0", {31'h0, branch_flag}, 32'h1);
        tick();
        branch_req = 1'b0;
        branch_pc  = 32'h0;
        sample();
        chk("t4_bflag_pend", {31'h0, branch_flag}, 32'h1);
        chk("t4_rpc_pend", redirect_pc, 32'h0000_0100);
        tick();
        trap_req = 1'b1;
        trap_pc  = 32'h0000_0180;
        sample();
        chk("t4_trap", {31'h0, trap}, 32'h1);
        chk("t4_bflag_drop", {31'h0, branch_flag}, 32'h0);
        chk("t4_rpc", redirect_pc, 32'h0000_0180);
        tick();
        clr_inputs();
        sample();
        chk("t4_trap_pend", {30'h0, trap, branch_flag}, 32'h2);
        chk("t4_rpc_pend2", redirect_pc, 32'h0000_0180);
        tick();
        sample();
        chk("t4_idle", {30'h0, trap, branch_flag}, 32'h0);
        chk("t4_rcnt", redirect_count, 32'd3);
        tick();

        // 5: same-cycle trap and branch
        trap_req   = 1'b1;
        trap_pc    = 32'h0000_0200;
        branch_req = 1'b1;
        branch_pc  = 32'h0000_0300;
        sample();
        chk("t5_flush", {30'h0, trap, branch_flag}, 32'h2);
        chk("t5_rpc", redirect_pc, 32'h0000_0200);
        tick();
        clr_inputs();
        sample();
        chk("t5_dropped", {30'h0, trap, branch_flag}, 32'h0);
        chk("t5_rcnt", redirect_count, 32'd4);
        tick();

        // 6: watchdog at 4 consecutive stall cycles, then async reset mid-pend
        stallreq_if = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t6_wdog_low", {31'h0, stall_timeout}, 32'h0);
            tick();
        end
        sample();
        chk("t6_wdog_set", {31'h0, stall_timeout}, 32'h1);
        tick();
        stallreq_if = 1'b0;
        tick();
        sample();
        chk("t6_wdog_sticky", {31'h0, stall_timeout}, 32'h1);
        tick();
        stallreq_mem = 1'b1;
        branch_req   = 1'b1;
        branch_pc    = 32'h0000_0400;
        tick();
        branch_req = 1'b0;
        branch_pc  = 32'h0;
        sample();
        chk("t6_pend", {30'h0, trap, branch_flag}, 32'h1);
        chk("t6_pend_rpc", redirect_pc, 32'h0000_0400);
        @(posedge clk);
        #2;
        clr_inputs();
        rst = 1'b1;
        #1;
        chk_all_zero("t6_async_rst");
        tick();
        rst = 1'b0;
        sample();
        chk_all_zero("t6_post_rst");

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d so far", passed_checks, total_checks);
        $fatal(1);
    end

endmodule
